branch_predictor_update_arbiter: RTL and testbench
==================================================

// Module: branch_predictor_update_arbiter
// PURPOSE
//  Sequences a single-port 2-bit-counter pattern history table (PHT) shared by fetch lookups and
//  execute-stage branch resolutions. Buffers resolved outcomes in a FIFO, performs read-modify-write
//  updates in lookup-free cycles, forces updates past a starvation limit, and initialises the table after reset.
// PARAMETERS
//  INDEX_WIDTH   6  PHT index width; table depth 2**INDEX_WIDTH
//  QUEUE_DEPTH   4  resolve FIFO entries (power of two, >=2)
//  STARVE_LIMIT  8  cycles an update may wait before lookups are stalled for it
// PORTS
//  clk            in   1            clock
//  rst            in   1            reset, synchronous, active-high
//  lookup_valid   in   1            fetch requests prediction for lookup_index
//  lookup_index   in   INDEX_WIDTH  PHT index of fetch lookup
//  lookup_stall   out  1            lookup not granted this cycle; fetch holds request
//  pred_valid     out  1            prediction valid (lookup granted previous cycle)
//  pred_taken     out  1            predicted direction = table_rdata[1]
//  resolve_valid  in   1            execute resolved a branch
//  resolve_index  in   INDEX_WIDTH  PHT index of resolved branch
//  resolve_taken  in   1            actual outcome
//  resolve_ready  out  1            FIFO can accept; execute holds resolve_* while low
//  table_en       out  1            PHT port access this cycle
//  table_we       out  1            1 = write, 0 = read
//  table_index    out  INDEX_WIDTH  PHT address
//  table_wdata    out  2            counter write data
//  table_rdata    in   2            counter read data, valid cycle after a read
// BEHAVIOUR
//  Reset: FIFO flushed, starve counter 0, FSM->INIT, init pointer 0; pred_valid=0, table_en=0,
//   table_we=0, resolve_ready=0, lookup_stall=1. Reset mid-operation discards queued/in-flight updates.
//  FSM states: INIT, IDLE, RD, WR.
//   INIT: one write per cycle, table_wdata=2'b01, index = init pointer 0..2**INDEX_WIDTH-1;
//    lookup_stall=1, resolve_ready=0; after last index -> IDLE (2**INDEX_WIDTH cycles).
//   IDLE: lookup_valid -> grant read (table_en=1, we=0, index=lookup_index), lookup_stall=0.
//    Else if FIFO non-empty -> issue read of head index, -> RD. Forced (starve count==STARVE_LIMIT):
//    head read issued even with lookup_valid; lookup_stall=1.
//   RD: capture table_rdata into latch; same-cycle port arbitration as IDLE; head write needs
//    port: if lookup_valid and not forced -> lookup granted, -> WR (pending write);
//    else write issued, FIFO popped, -> IDLE.
//   WR: write head with next(latched) when no lookup or forced; pop FIFO -> IDLE. Else lookup granted.
//  Counter update next(c, t): t=1: 00->01, 01->11, 10->11, 11->11; t=0: 00->00, 01->00, 10->01, 11->10.
//  Starve counter: increments each cycle an update is pending (FIFO non-empty) and a lookup is granted;
//   saturates at STARVE_LIMIT; cleared on every update write. Forced state persists until that write.
//  pred_valid = 1 exactly one cycle after a granted lookup; pred_taken = table_rdata[1] then, else 0.
//  FIFO: resolve_ready = !full outside INIT; enqueue on resolve_valid & resolve_ready. When full,
//   ready stays low even on a pop cycle (no same-cycle enqueue-on-full). Empty + enqueue: entry
//   visible to FSM next cycle. Pointers wrap modulo QUEUE_DEPTH.
//  Duplicate indices in FIFO are applied in order; each RMW reads after prior write completes.
//  Lookup/update to same index in same cycle: port serialised; lookup sees pre-update value.
// CONFIGURATION
//  BP_ARB_PERF_COUNTER_EN defined: adds outputs perf_stall_cycles[31:0] (cycles lookup_stall=1 with
//   lookup_valid=1, outside INIT) and perf_forced_updates[31:0] (forced head reads); both 0 on reset,
//   wrap at 2**32. Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  Reset, INDEX_WIDTH=6 -> 64 INIT writes of 2'b01, lookup_stall=1 throughout, then IDLE; lookup idx 5 -> pred_taken=0.
//  Resolve idx 5 taken twice, no lookups -> table idx5 = 01->11->11; later lookup idx 5 -> pred_taken=1.
//  Enqueue 4 resolves with lookup_valid held -> resolve_ready=0 on 5th; after 8 stalled cycles
//   lookup_stall=1 for forced RD and WR, one entry popped, resolve_ready=1 next cycle.
//  Idx 7 at 11; resolve not-taken x3 -> 10, 01, 00; pred_taken for idx 7 after each: 1, 0, 0.
//  Assert rst while in WR with 3 queued -> FIFO empty, INIT restarts at index 0, no write of pending value.
//  With BP_ARB_PERF_COUNTER_EN: forced scenario above -> perf_forced_updates=1, perf_stall_cycles=2.

Source files
------------

// File: rtl/branch_predictor_update_arbiter.sv
// rtl/branch_predictor_update_arbiter.sv - single-port 2-bit PHT arbiter: fetch lookups, queued RMW updates, init sweep.
// Define BP_ARB_PERF_COUNTER_EN to add perf_stall_cycles / perf_forced_updates outputs.
module branch_predictor_update_arbiter #(
  parameter int INDEX_WIDTH  = 6,
  parameter int QUEUE_DEPTH  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lookup_valid,
  input  logic [INDEX_WIDTH-1:0] lookup_index,
  output logic                   lookup_stall,
  output logic                   pred_valid,
  output logic                   pred_taken,
  input  logic                   resolve_valid,
  input  logic [INDEX_WIDTH-1:0] resolve_index,
  input  logic                   resolve_taken,
  output logic                   resolve_ready,
  output logic                   table_en,
  output logic                   table_we,
  output logic [INDEX_WIDTH-1:0] table_index,
  output logic [1:0]             table_wdata,
`ifdef BP_ARB_PERF_COUNTER_EN
  output logic [31:0]            perf_stall_cycles,
  output logic [31:0]            perf_forced_updates,
`endif
  input  logic [1:0]             table_rdata
);

  localparam int PTR_W    = $clog2(QUEUE_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RD, S_WR} state_t;

  state_t                 state;
  logic [INDEX_WIDTH-1:0] init_ptr;
  logic [INDEX_WIDTH-1:0] q_index [QUEUE_DEPTH];
  logic                   q_taken [QUEUE_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [STARVE_W-1:0]    starve_cnt;
  logic [1:0]             latch;

  logic                   pending;
  logic                   full;
  logic                   forced;
  logic                   enq;
  logic                   grant;
  logic                   head_read;
  logic                   do_write;
  logic [1:0]             upd_src;
  logic [INDEX_WIDTH-1:0] head_index;
  logic                   head_taken;

  function automatic logic [1:0] next_counter(input logic [1:0] c, input logic t);
    logic [1:0] n;
    case ({t, c})
      3'b1_00: n = 2'b01;
      3'b1_01: n = 2'b11;
      3'b1_10: n = 2'b11;
      3'b1_11: n = 2'b11;
      3'b0_00: n = 2'b00;
      3'b0_01: n = 2'b00;
      3'b0_10: n = 2'b01;
      default: n = 2'b10;
    endcase
    return n;
  endfunction

  assign pending       = (count != '0);
  assign full          = (count == CNT_W'(QUEUE_DEPTH));
  assign forced        = (starve_cnt == STARVE_W'(STARVE_LIMIT));
  assign head_index    = q_index[rd_ptr];
  assign head_taken    = q_taken[rd_ptr];
  assign resolve_ready = !rst && (state != S_INIT) && !full;
  assign enq           = resolve_valid && resolve_ready;
  assign pred_taken    = pred_valid && table_rdata[1];

  // A starved update owns the port until its write lands, whatever state it is in.
  always_comb begin
    lookup_stall = rst || (state == S_INIT) || (pending && forced);
    grant        = 1'b0;
    head_read    = 1'b0;
    do_write     = 1'b0;
    upd_src      = latch;
    table_en     = 1'b0;
    table_we     = 1'b0;
    table_index  = lookup_index;
    table_wdata  = 2'b00;
    if (!rst) begin
      case (state)
        S_INIT: begin
          table_en    = 1'b1;
          table_we    = 1'b1;
          table_index = init_ptr;
          table_wdata = 2'b01;
        end
        S_IDLE: begin
          if (lookup_valid && !lookup_stall) grant = 1'b1;
          else if (pending)                  head_read = 1'b1;
        end
        S_RD: begin
          if (lookup_valid && !lookup_stall) grant = 1'b1;
          else begin
            do_write = 1'b1;
            upd_src  = table_rdata;
          end
        end
        S_WR: begin
          if (lookup_valid && !lookup_stall) grant = 1'b1;
          else                               do_write = 1'b1;
        end
        default: ;
      endcase
      if (grant) begin
        table_en    = 1'b1;
        table_index = lookup_index;
      end else if (head_read) begin
        table_en    = 1'b1;
        table_index = head_index;
      end else if (do_write) begin
        table_en    = 1'b1;
        table_we    = 1'b1;
        table_index = head_index;
        table_wdata = next_counter(upd_src, head_taken);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INIT;
      init_ptr   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      latch      <= 2'b00;
      pred_valid <= 1'b0;
    end else begin
      pred_valid <= grant;
      if (enq) begin
        q_index[wr_ptr] <= resolve_index;
        q_taken[wr_ptr] <= resolve_taken;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (do_write) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, do_write})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (do_write)                          starve_cnt <= '0;
      else if (grant && pending && !forced)  starve_cnt <= starve_cnt + STARVE_W'(1);
      case (state)
        S_INIT: begin
          init_ptr <= init_ptr + INDEX_WIDTH'(1);
          if (init_ptr == {INDEX_WIDTH{1'b1}}) state <= S_IDLE;
        end
        S_IDLE: if (head_read) state <= S_RD;
        S_RD: begin
          // Read data is only present this cycle; keep it for a deferred write.
          latch <= table_rdata;
          state <= grant ? S_WR : S_IDLE;
        end
        S_WR: if (do_write) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BP_ARB_PERF_COUNTER_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles   <= '0;
      perf_forced_updates <= '0;
    end else begin
      if (lookup_valid && lookup_stall && (state != S_INIT))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (head_read && forced)
        perf_forced_updates <= perf_forced_updates + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor_update_arbiter.sv
// tb/tb_branch_predictor_update_arbiter.sv - self-checking bench for branch_predictor_update_arbiter.
// Optional BP_ARB_PERF_COUNTER_EN also checks the perf counters.
module tb_branch_predictor_update_arbiter;
  localparam int IW = 6;
  localparam int QD = 4;
  localparam int SL = 8;
  localparam int NE = 1 << IW;

  logic          clk = 1'b0;
  logic          rst;
  logic          lookup_valid;
  logic [IW-1:0] lookup_index;
  logic          lookup_stall;
  logic          pred_valid;
  logic          pred_taken;
  logic          resolve_valid;
  logic [IW-1:0] resolve_index;
  logic          resolve_taken;
  logic          resolve_ready;
  logic          table_en;
  logic          table_we;
  logic [IW-1:0] table_index;
  logic [1:0]    table_wdata;
  logic [1:0]    table_rdata;
`ifdef BP_ARB_PERF_COUNTER_EN
  logic [31:0]   perf_stall_cycles;
  logic [31:0]   perf_forced_updates;
  logic [31:0]   snap_stall;
  logic [31:0]   snap_forced;
`endif

  branch_predictor_update_arbiter #(.INDEX_WIDTH(IW), .QUEUE_DEPTH(QD), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_index(lookup_index), .lookup_stall(lookup_stall),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .resolve_valid(resolve_valid), .resolve_index(resolve_index), .resolve_taken(resolve_taken),
    .resolve_ready(resolve_ready),
    .table_en(table_en), .table_we(table_we), .table_index(table_index), .table_wdata(table_wdata),
`ifdef BP_ARB_PERF_COUNTER_EN
    .perf_stall_cycles(perf_stall_cycles), .perf_forced_updates(perf_forced_updates),
`endif
    .table_rdata(table_rdata)
  );

  always #5 clk = ~clk;

  // Single-port PHT storage with one-cycle read latency.
  logic [1:0] mem [NE];
  always @(posedge clk) begin
    if (table_en) begin
      if (table_we) mem[table_index] <= table_wdata;
      else          table_rdata <= mem[table_index];
    end
  end

  typedef struct { logic [IW-1:0] idx; logic t; } res_t;
  res_t       pending[$];
  logic [1:0] ref_pht [NE];
  int         starve;
  int         init_left;
  int         init_writes;
  logic       exp_pv, exp_pt;
  logic       last_stall, last_ready, last_write, last_pt;
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] upd(input logic [1:0] c, input logic t);
    if (t) return (c == 2'd0) ? 2'd1 : 2'd3;
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  // One clock: check outputs against the reference, advance the reference, step the clock.
  task automatic cycle();
    logic granted;
    logic rdy;
    res_t h;
    #1;
    last_stall = lookup_stall;
    last_ready = resolve_ready;
    last_write = table_en && table_we;
    last_pt    = pred_taken;
    if (rst) begin
      chk("rst_stall", lookup_stall, 1);
      chk("rst_ready", resolve_ready, 0);
      chk("rst_table_en", table_en, 0);
      pending.delete();
      starve = 0; init_left = NE; init_writes = 0;
      for (int i = 0; i < NE; i++) ref_pht[i] = 2'b01;
      exp_pv = 0; exp_pt = 0;
    end else begin
      chk("pred_valid", pred_valid, exp_pv);
      chk("pred_taken", pred_taken, exp_pt);
      exp_pv = 0; exp_pt = 0;
      if (init_left > 0) begin
        chk("init_en", table_en, 1);
        chk("init_we", table_we, 1);
        chk("init_index", table_index, NE - init_left);
        chk("init_wdata", table_wdata, 2'b01);
        chk("init_stall", lookup_stall, 1);
        chk("init_ready", resolve_ready, 0);
        init_left--; init_writes++;
      end else begin
        rdy = (pending.size() < QD);
        chk("resolve_ready", resolve_ready, rdy);
        if (lookup_valid) chk("lookup_stall", lookup_stall, starve == SL);
        granted = lookup_valid && (starve != SL);
        if (granted) begin
          chk("grant_en", table_en, 1);
          chk("grant_we", table_we, 0);
          chk("grant_index", table_index, lookup_index);
          exp_pv = 1; exp_pt = ref_pht[lookup_index][1];
          if (pending.size() > 0 && starve < SL) starve++;
        end else if (table_en && table_we) begin
          chk("wr_pending", pending.size() != 0, 1);
          if (pending.size() != 0) begin
            h = pending.pop_front();
            chk("wr_index", table_index, h.idx);
            chk("wr_data", table_wdata, upd(ref_pht[h.idx], h.t));
            ref_pht[h.idx] = upd(ref_pht[h.idx], h.t);
          end
          starve = 0;
        end else if (table_en) begin
          chk("rd_pending", pending.size() != 0, 1);
          if (pending.size() != 0) chk("rd_index", table_index, pending[0].idx);
        end
        if (resolve_valid && rdy) pending.push_back('{resolve_index, resolve_taken});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    lookup_valid = 0; resolve_valid = 0;
    for (int i = 0; i < 16; i++) cycle();
    chk("drain_empty", pending.size(), 0);
  endtask

  task automatic do_lookup(input logic [IW-1:0] idx, input logic exp, input string tag);
    lookup_valid = 1; lookup_index = idx;
    cycle();
    lookup_valid = 0;
    cycle();
    chk(tag, last_pt, exp);
  endtask

  task automatic enqueue(input logic [IW-1:0] idx, input logic t);
    resolve_valid = 1; resolve_index = idx; resolve_taken = t;
    cycle();
    resolve_valid = 0;
  endtask

  logic exp7 [3];
  int   mism;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp7[0] = 1; exp7[1] = 0; exp7[2] = 0;
    rst = 1; lookup_valid = 0; lookup_index = '0;
    resolve_valid = 0; resolve_index = '0; resolve_taken = 0;
    @(negedge clk);

    // Reset and initialisation sweep with fetch already requesting
    for (int i = 0; i < 3; i++) cycle();
    rst = 0; lookup_valid = 1; lookup_index = 6'd5;
    for (int i = 0; i < NE; i++) cycle();
    chk("init_writes", init_writes, NE);
    do_lookup(6'd5, 0, "pred_idx5_init");
    chk("ready_after_init", last_ready, 1);

    // Two taken resolves on idx 5
    enqueue(6'd5, 1);
    enqueue(6'd5, 1);
    drain();
    chk("mem5", mem[5], 2'b11);
    do_lookup(6'd5, 1, "pred_idx5_taken");

    // Starvation: fill queue under continuous lookups
`ifdef BP_ARB_PERF_COUNTER_EN
    snap_stall = perf_stall_cycles; snap_forced = perf_forced_updates;
`endif
    lookup_valid = 1;
    for (int k = 0; k < 4; k++) begin
      lookup_index = 6'($urandom_range(32, 63));
      resolve_valid = 1; resolve_index = 6'(10 + k); resolve_taken = k[0];
      cycle();
    end
    resolve_index = 6'd14; resolve_taken = 1;
    lookup_index = 6'($urandom_range(32, 63));
    cycle();
    chk("full_ready_low", last_ready, 0);
    for (int k = 5; k < 9; k++) begin
      lookup_index = 6'($urandom_range(32, 63));
      cycle();
      chk("prestarve_stall", last_stall, 0);
    end
    cycle();
    chk("forced_rd_stall", last_stall, 1);
    cycle();
    chk("forced_wr_stall", last_stall, 1);
    chk("forced_write", last_write, 1);
    cycle();
    chk("ready_after_pop", last_ready, 1);
`ifdef BP_ARB_PERF_COUNTER_EN
    chk("perf_forced", perf_forced_updates - snap_forced, 1);
    chk("perf_stall", perf_stall_cycles - snap_stall, 2);
`endif
    drain();

    // Counter walk-down on idx 7
    enqueue(6'd7, 1);
    enqueue(6'd7, 1);
    drain();
    for (int k = 0; k < 3; k++) begin
      enqueue(6'd7, 0);
      drain();
      do_lookup(6'd7, exp7[k], "pred_idx7_nt");
    end

    // Random traffic on a small index range to provoke duplicates and conflicts
    for (int c = 0; c < 400; c++) begin
      lookup_valid = ($urandom_range(0, 9) < 6);
      lookup_index = 6'($urandom_range(0, 7));
      if (!(resolve_valid && !last_ready)) begin
        resolve_valid = ($urandom_range(0, 2) == 0);
        resolve_index = 6'($urandom_range(0, 7));
        resolve_taken = 1'($urandom_range(0, 1));
      end
      cycle();
    end
    drain();
    mism = 0;
    for (int i = 0; i < NE; i++) if (mem[i] !== ref_pht[i]) mism++;
    chk("table_match", mism, 0);

    // Reset while a deferred write is pending with three queued
    enqueue(6'd20, 1);
    enqueue(6'd20, 1);
    lookup_valid = 1; lookup_index = 6'd3;
    enqueue(6'd20, 1);
    chk("queued_before_rst", pending.size(), 3);
    rst = 1;
    cycle();
    chk("rst_no_write", last_write, 0);
    cycle();
    rst = 0; lookup_valid = 0;
    for (int i = 0; i < NE; i++) cycle();
    chk("reinit_writes", init_writes, NE);
    drain();
    chk("mem20_reinit", mem[20], 2'b01);
    do_lookup(6'd20, 0, "pred_idx20_reinit");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
